instruction_sequencer: RTL and testbench

Fetches 16-bit program words from a synchronous instruction memory and issues one 15-bit core instruction per clock to the `instruction` input of the compute core(s). It sits directly upstream of the core. It owns the program counter and executes its own control words: jump, halt, loop and wait. The core has no PC, so every cycle in which no real instruction is available is filled with a NOP.

---
 rtl/instruction_sequencer_if.sv | 26 ++
 rtl/instruction_sequencer.sv | 142 ++++++++++++++
 tb/tb_instruction_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// Handshake and memory bundle between the instruction sequencer, its host,
// and the synchronous instruction memory.
interface instruction_sequencer_if #(
    parameter int INSTRUCTION_WIDTH  = 15,
    parameter int IMEM_ADDRESS_WIDTH = 12
);
    logic                          start;
    logic [IMEM_ADDRESS_WIDTH-1:0] start_pc;
    logic                          stall;
    logic [IMEM_ADDRESS_WIDTH-1:0] imem_address;
    logic [INSTRUCTION_WIDTH:0]    imem_data;
    logic [INSTRUCTION_WIDTH-1:0]  instruction;
    logic                          issue;
    logic                          running;
    logic                          done;

    modport master (
        output start, start_pc, stall, imem_data,
        input  imem_address, instruction, issue, running, done
    );

    modport slave (
        input  start, start_pc, stall, imem_data,
        output imem_address, instruction, issue, running, done
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetches program words from a 1-cycle-latency instruction memory and issues one
// core instruction (or NOP) per clock, executing its own JMP/HALT/LOOP/WAIT words.
//
// state | meaning
// IDLE  | no program running, NOP issued, waiting for start
// RUN   | fetching and decoding program words
// WAIT  | burning wait_count NOP cycles, fetch address parked after the WAIT word
module instruction_sequencer #(
    parameter int                           INSTRUCTION_WIDTH  = 15,
    parameter int                           IMEM_ADDRESS_WIDTH = 12,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP                = 15'h2800
) (
    input  logic                   clk,
    input  logic                   reset,
    instruction_sequencer_if.slave bus
);
    localparam int WORD_WIDTH = INSTRUCTION_WIDTH + 1;

    localparam logic [2:0] OP_JMP     = 3'd0;
    localparam logic [2:0] OP_HALT    = 3'd1;
    localparam logic [2:0] OP_LOOPSET = 3'd2;
    localparam logic [2:0] OP_LOOPJ   = 3'd3;
    localparam logic [2:0] OP_WAIT    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT
    } state_t;

    state_t                         state;
    logic [IMEM_ADDRESS_WIDTH-1:0]  pc;
    logic [IMEM_ADDRESS_WIDTH-1:0]  decode_pc;
    logic                           fetch_valid;
    logic [IMEM_ADDRESS_WIDTH-1:0]  loop_count;
    logic [IMEM_ADDRESS_WIDTH-1:0]  wait_count;
    logic [INSTRUCTION_WIDTH-1:0]   instruction_q;
    logic                           issue_q;
    logic                           done_q;

    logic                           word_is_ctrl;
    logic [2:0]                     op;
    logic [IMEM_ADDRESS_WIDTH-1:0]  arg;

    assign word_is_ctrl = bus.imem_data[WORD_WIDTH-1];
    assign op           = bus.imem_data[WORD_WIDTH-2 -: 3];
    assign arg          = bus.imem_data[IMEM_ADDRESS_WIDTH-1:0];

    assign bus.imem_address = pc;
    assign bus.instruction  = instruction_q;
    assign bus.issue        = issue_q;
    assign bus.done         = done_q;
    assign bus.running      = (state != IDLE);

    // fetch_valid marks that imem_data holds the word at decode_pc; every
    // redirect clears it so the word already in flight is squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= '0;
            decode_pc     <= '0;
            fetch_valid   <= 1'b0;
            loop_count    <= '0;
            wait_count    <= '0;
            instruction_q <= NOP;
            issue_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            instruction_q <= NOP;
            issue_q       <= 1'b0;
            done_q        <= 1'b0;
            case (state)
                IDLE: begin
                    fetch_valid <= 1'b0;
                    if (bus.start) begin
                        pc    <= bus.start_pc;
                        state <= RUN;
                    end
                end
                RUN, WAIT: begin
                    if (bus.stall) begin
                        // rewind to the undecoded word so nothing is lost on release
                        if (fetch_valid) begin
                            pc <= decode_pc;
                        end
                        fetch_valid <= 1'b0;
                    end else if (state == WAIT) begin
                        wait_count <= wait_count - 1'b1;
                        if (wait_count == {{(IMEM_ADDRESS_WIDTH-1){1'b0}}, 1'b1}) begin
                            state <= RUN;
                        end
                    end else begin
                        decode_pc   <= pc;
                        pc          <= pc + 1'b1;
                        fetch_valid <= 1'b1;
                        if (fetch_valid) begin
                            if (!word_is_ctrl) begin
                                instruction_q <= bus.imem_data[INSTRUCTION_WIDTH-1:0];
                                issue_q       <= 1'b1;
                            end else begin
                                case (op)
                                    OP_JMP: begin
                                        pc          <= arg;
                                        fetch_valid <= 1'b0;
                                    end
                                    OP_HALT: begin
                                        state       <= IDLE;
                                        done_q      <= 1'b1;
                                        fetch_valid <= 1'b0;
                                    end
                                    OP_LOOPSET: begin
                                        loop_count <= arg;
                                    end
                                    OP_LOOPJ: begin
                                        if (loop_count != '0) begin
                                            loop_count  <= loop_count - 1'b1;
                                            pc          <= arg;
                                            fetch_valid <= 1'b0;
                                        end
                                    end
                                    OP_WAIT: begin
                                        if (arg != '0) begin
                                            state       <= WAIT;
                                            wait_count  <= arg;
                                            pc          <= decode_pc + 1'b1;
                                            fetch_valid <= 1'b0;
                                        end
                                    end
                                    default: begin
                                    end
                                endcase
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: directed programs with literal timing expectations plus
// randomized programs, stalls, starts and resets against an architectural model.
module tb_instruction_sequencer;
    localparam logic [14:0] NOP  = 15'h2800;
    localparam logic [15:0] HALT = 16'h9000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_sequencer_if bus ();

    instruction_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [15:0] mem [4096];
    always @(posedge clk) bus.imem_data <= mem[bus.imem_address];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // architectural model: program counter, loop register and owed NOP bubbles
    bit          m_idle;
    logic [11:0] m_pc;
    logic [11:0] m_lc;
    int          m_owed;
    logic [14:0] exp_instr;
    logic        exp_issue;
    logic        exp_done;
    logic        exp_running;

    logic [14:0] iss_v [$];
    int          iss_t [$];
    int          done_t [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_idle      = 1'b1;
        m_pc        = '0;
        m_lc        = '0;
        m_owed      = 0;
        exp_instr   = NOP;
        exp_issue   = 1'b0;
        exp_done    = 1'b0;
        exp_running = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        logic [11:0] k;
        exp_instr = NOP;
        exp_issue = 1'b0;
        exp_done  = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_idle) begin
            if (bus.start) begin
                m_idle = 1'b0;
                m_pc   = bus.start_pc;
                m_owed = 1;
            end
        end else if (bus.stall) begin
            if (m_owed == 0) m_owed = 1;
        end else if (m_owed > 0) begin
            m_owed--;
        end else begin
            w = mem[m_pc];
            k = w[11:0];
            if (!w[15]) begin
                exp_instr = w[14:0];
                exp_issue = 1'b1;
                m_pc      = m_pc + 12'd1;
            end else begin
                case (w[14:12])
                    3'd0: begin m_pc = k; m_owed = 1; end
                    3'd1: begin m_idle = 1'b1; exp_done = 1'b1; end
                    3'd2: begin m_lc = k; m_pc = m_pc + 12'd1; end
                    3'd3: begin
                        if (m_lc != 0) begin
                            m_lc   = m_lc - 12'd1;
                            m_pc   = k;
                            m_owed = 1;
                        end else begin
                            m_pc = m_pc + 12'd1;
                        end
                    end
                    3'd4: begin
                        m_pc   = m_pc + 12'd1;
                        m_owed = (k == 0) ? 0 : int'(k) + 1;
                    end
                    default: m_pc = m_pc + 12'd1;
                endcase
            end
        end
        exp_running = !m_idle;
    endtask

    task automatic check_outputs();
        check("instruction", 32'(bus.instruction), 32'(exp_instr));
        check("issue", 32'(bus.issue), 32'(exp_issue));
        check("running", 32'(bus.running), 32'(exp_running));
        check("done", 32'(bus.done), 32'(exp_done));
    endtask

    // called at a negedge with inputs set; returns at the following negedge
    task automatic cycle();
        @(posedge clk);
        model_step();
        #2;
        cyc++;
        check_outputs();
        if (bus.issue === 1'b1) begin
            iss_v.push_back(bus.instruction);
            iss_t.push_back(cyc);
        end
        if (bus.done === 1'b1) done_t.push_back(cyc);
        @(negedge clk);
    endtask

    task automatic clear_log();
        iss_v.delete();
        iss_t.delete();
        done_t.delete();
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 4096; a++) mem[a] = HALT;
    endtask

    task automatic launch(input logic [11:0] pc0, output int t0);
        bus.start    = 1'b1;
        bus.start_pc = pc0;
        t0           = cyc + 1;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic expect_issue(string name, int idx, logic [14:0] v, int t);
        if (idx < iss_v.size()) begin
            check({name, "_val"}, 32'(iss_v[idx]), 32'(v));
            check({name, "_cyc"}, iss_t[idx], t);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: issue #%0d missing, expected %h at cycle %0d", name, idx, v, t);
        end
    endtask

    task automatic expect_done(string name, int t);
        check({name, "_count"}, done_t.size(), 1);
        if (done_t.size() > 0) check({name, "_cyc"}, done_t[0], t);
    endtask

    function automatic logic [15:0] rand_word();
        int          r;
        logic [11:0] k;
        r = $urandom_range(0, 99);
        k = 12'($urandom_range(0, 4095));
        if (r < 60)      return {1'b0, 15'($urandom)};
        else if (r < 68) return {4'h8, k};
        else if (r < 71) return {4'h9, k};
        else if (r < 79) return {4'hA, 12'($urandom_range(0, 4))};
        else if (r < 89) return {4'hB, k};
        else if (r < 96) return {4'hC, 12'($urandom_range(0, 6))};
        else             return {1'b1, 3'($urandom_range(5, 7)), k};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required end before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.start    = 1'b0;
        bus.start_pc = '0;
        bus.stall    = 1'b0;
        reset        = 1'b1;
        model_reset();
        clear_mem();
        @(negedge clk);
        cycle();
        check("rst_instruction", 32'(bus.instruction), 32'h2800);
        check("rst_issue", 32'(bus.issue), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_imem_address", 32'(bus.imem_address), 0);
        reset = 1'b0;
        cycle();

        // straight-line program
        clear_log();
        mem[0] = 16'h1234; mem[1] = 16'h0001; mem[2] = HALT;
        launch(12'h000, t0);
        repeat (7) cycle();
        check("sl_issues", iss_v.size(), 2);
        expect_issue("sl_first", 0, 15'h1234, t0 + 2);
        expect_issue("sl_second", 1, 15'h0001, t0 + 3);
        expect_done("sl_done", t0 + 4);

        // LOOPSET 3 / body / LOOPJ / HALT
        clear_mem();
        clear_log();
        mem[0] = 16'hA003; mem[1] = 16'h0005; mem[2] = 16'hB001; mem[3] = HALT;
        launch(12'h000, t0);
        repeat (18) cycle();
        check("loop_issues", iss_v.size(), 4);
        for (int i = 0; i < 4; i++) expect_issue("loop_body", i, 15'h0005, t0 + 3 + 3 * i);
        expect_done("loop_done", t0 + 14);
        check("loop_count_end", 32'(dut.loop_count), 0);

        // WAIT 5 between two instructions
        clear_mem();
        clear_log();
        mem[0] = 16'h0011; mem[1] = 16'hC005; mem[2] = 16'h0022; mem[3] = HALT;
        launch(12'h000, t0);
        repeat (14) cycle();
        check("wait_issues", iss_v.size(), 2);
        expect_issue("wait_before", 0, 15'h0011, t0 + 2);
        expect_issue("wait_after", 1, 15'h0022, t0 + 10);
        expect_done("wait_done", t0 + 11);

        // stall held for 3 cycles while a JMP sits on imem_data
        clear_mem();
        clear_log();
        mem[0] = 16'h0101; mem[1] = 16'h8008; mem[2] = 16'h0BAD; mem[8] = 16'h0088;
        launch(12'h000, t0);
        cycle();
        cycle();
        bus.stall = 1'b1;
        repeat (3) cycle();
        bus.stall = 1'b0;
        repeat (8) cycle();
        check("stall_issues", iss_v.size(), 2);
        expect_issue("stall_pre", 0, 15'h0101, t0 + 2);
        expect_issue("stall_target", 1, 15'h0088, t0 + 9);
        expect_done("stall_done", t0 + 10);

        // PC wrap with an ignored start during RUN
        clear_mem();
        clear_log();
        mem[12'hFFF] = 16'h0FFF; mem[0] = 16'h0777; mem[5] = 16'h0555;
        launch(12'hFFF, t0);
        check("wrap_imem_address", 32'(bus.imem_address), 32'h0FFF);
        cycle();
        bus.start    = 1'b1;
        bus.start_pc = 12'h005;
        cycle();
        bus.start = 1'b0;
        repeat (6) cycle();
        check("wrap_issues", iss_v.size(), 2);
        expect_issue("wrap_last", 0, 15'h0FFF, t0 + 2);
        expect_issue("wrap_first", 1, 15'h0777, t0 + 3);
        expect_done("wrap_done", t0 + 4);

        // reset in the middle of an endless loop
        clear_mem();
        clear_log();
        mem[0] = 16'h0123; mem[1] = 16'h8000; mem[12'h010] = 16'h0345;
        launch(12'h000, t0);
        repeat (6) cycle();
        reset = 1'b1;
        #1;
        model_reset();
        check("midrst_instruction", 32'(bus.instruction), 32'h2800);
        check("midrst_issue", 32'(bus.issue), 0);
        check("midrst_running", 32'(bus.running), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_imem_address", 32'(bus.imem_address), 0);
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        clear_log();
        launch(12'h010, t0);
        repeat (5) cycle();
        check("postrst_issues", iss_v.size(), 1);
        expect_issue("postrst_first", 0, 15'h0345, t0 + 2);
        expect_done("postrst_done", t0 + 3);

        // randomized programs, stalls, starts and resets
        for (int t = 0; t < 12; t++) begin
            reset = 1'b1;
            model_reset();
            cycle();
            reset = 1'b0;
            for (int a = 0; a < 4096; a++) mem[a] = rand_word();
            launch(12'($urandom_range(0, 4095)), t0);
            repeat (300) begin
                bus.stall    = ($urandom_range(0, 99) < 15);
                bus.start    = ($urandom_range(0, 99) < 8);
                bus.start_pc = 12'($urandom_range(0, 4095));
                if ($urandom_range(0, 199) == 0) begin
                    reset = 1'b1;
                    model_reset();
                    cycle();
                    reset = 1'b0;
                end
                cycle();
            end
            bus.stall = 1'b0;
            bus.start = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
